// File: rtl/instruction_decode.sv
// instruction_decode -- RV32I subset decode stage with hazard detection,
// early beq resolution and the ID/EX pipeline register.
//
// Decodes add/sub/and/or, addi, lw, sw and beq; every other encoding is a
// bubble. Holds the 32x32 register file (x0 hard-wired to zero).
//
// Optional feature macro: RF_WRITE_BYPASS_EN
//   defined   : a same-cycle write-back to a register being read is bypassed
//               onto the read port.
//   undefined : that case is treated as a hazard and stalls for one cycle.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   IF_ID_pc, IF_ID_inst  : instruction presented by the IF/ID register
//   wb_reg_write/rd/data  : register write-back port
//   ex_mem_*              : EX/MEM state used for beq forwarding and hazards
//   pc_write, IF_ID_write : fetch enables (0 while stalling)
//   IF_flush, pc_src      : taken-branch redirect
//   branch, br_eq         : beq decoded / forwarded operands equal
//   pc_branch             : IF_ID_pc + B-immediate
//   ID_EX_*               : ID/EX pipeline register outputs
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_ID_pc,
  input  logic [31:0] IF_ID_inst,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_reg_write,
  input  logic        ex_mem_mem_read,
  input  logic [4:0]  ex_mem_rd,
  input  logic [31:0] ex_mem_alu_result,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_flush,
  output logic        pc_src,
  output logic        branch,
  output logic        br_eq,
  output logic [31:0] pc_branch,
  output logic [31:0] ID_EX_pc,
  output logic [31:0] ID_EX_rs1_data,
  output logic [31:0] ID_EX_rs2_data,
  output logic [31:0] ID_EX_imm,
  output logic [4:0]  ID_EX_rs1,
  output logic [4:0]  ID_EX_rs2,
  output logic [4:0]  ID_EX_rd,
  output logic [3:0]  ID_EX_alu_op,
  output logic        ID_EX_alu_src,
  output logic        ID_EX_mem_read,
  output logic        ID_EX_mem_write,
  output logic        ID_EX_reg_write,
  output logic        ID_EX_mem_to_reg
);

  typedef enum logic [3:0] {
    INS_NONE,
    INS_ADD,
    INS_SUB,
    INS_AND,
    INS_OR,
    INS_ADDI,
    INS_LW,
    INS_SW,
    INS_BEQ
  } insn_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;

  assign opcode = IF_ID_inst[6:0];
  assign funct3 = IF_ID_inst[14:12];
  assign funct7 = IF_ID_inst[31:25];
  assign rs1    = IF_ID_inst[19:15];
  assign rs2    = IF_ID_inst[24:20];
  assign rd     = IF_ID_inst[11:7];

  assign imm_i = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:20]};
  assign imm_s = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:25], IF_ID_inst[11:7]};
  assign imm_b = {{19{IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[7],
                  IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0};

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  insn_e insn;

  always_comb begin
    insn = INS_NONE;
    unique case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000)      insn = INS_ADD;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) insn = INS_SUB;
        else if (funct7 == 7'b0000000 && funct3 == 3'b111) insn = INS_AND;
        else if (funct7 == 7'b0000000 && funct3 == 3'b110) insn = INS_OR;
      end
      7'b0010011: if (funct3 == 3'b000) insn = INS_ADDI;
      7'b0000011: if (funct3 == 3'b010) insn = INS_LW;
      7'b0100011: if (funct3 == 3'b010) insn = INS_SW;
      7'b1100011: if (funct3 == 3'b000) insn = INS_BEQ;
      default:    insn = INS_NONE;
    endcase
  end

  logic [3:0]  dec_alu_op;
  logic        dec_alu_src;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_reg_write;
  logic        dec_mem_to_reg;
  logic [31:0] dec_imm;
  logic        uses_rs2;
  logic        is_beq;

  always_comb begin
    dec_alu_op     = ALU_ADD;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_imm        = '0;
    uses_rs2       = 1'b0;
    is_beq         = 1'b0;
    unique case (insn)
      INS_ADD: begin dec_reg_write = 1'b1; uses_rs2 = 1'b1; end
      INS_SUB: begin dec_reg_write = 1'b1; uses_rs2 = 1'b1; dec_alu_op = ALU_SUB; end
      INS_AND: begin dec_reg_write = 1'b1; uses_rs2 = 1'b1; dec_alu_op = ALU_AND; end
      INS_OR:  begin dec_reg_write = 1'b1; uses_rs2 = 1'b1; dec_alu_op = ALU_OR;  end
      INS_ADDI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = imm_i;
      end
      INS_LW: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_imm        = imm_i;
      end
      INS_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        uses_rs2      = 1'b1;
        dec_imm       = imm_s;
      end
      INS_BEQ: begin
        is_beq   = 1'b1;
        uses_rs2 = 1'b1;
        dec_imm  = imm_b;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file: one synchronous write port, two combinational reads
  // ---------------------------------------------------------------------
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_reg_write && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Same-cycle write-back targeting a source register (never x0)
  logic wb_hit1;
  logic wb_hit2;
  assign wb_hit1 = wb_reg_write && (wb_rd != '0) && (wb_rd == rs1);
  assign wb_hit2 = wb_reg_write && (wb_rd != '0) && (wb_rd == rs2);

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  always_comb begin
    if (rs1 == '0)   rs1_val = '0;
`ifdef RF_WRITE_BYPASS_EN
    else if (wb_hit1) rs1_val = wb_data;
`endif
    else             rs1_val = regs[rs1];
  end

  always_comb begin
    if (rs2 == '0)   rs2_val = '0;
`ifdef RF_WRITE_BYPASS_EN
    else if (wb_hit2) rs2_val = wb_data;
`endif
    else             rs2_val = regs[rs2];
  end

  // ---------------------------------------------------------------------
  // Branch operand forwarding and comparison
  // ---------------------------------------------------------------------
  logic        ex_fwd1;
  logic        ex_fwd2;
  logic [31:0] br_op1;
  logic [31:0] br_op2;

  // A load in EX/MEM has no value yet; that case is stalled below instead.
  assign ex_fwd1 = ex_mem_reg_write && !ex_mem_mem_read &&
                   (ex_mem_rd != '0) && (ex_mem_rd == rs1);
  assign ex_fwd2 = ex_mem_reg_write && !ex_mem_mem_read &&
                   (ex_mem_rd != '0) && (ex_mem_rd == rs2);
  assign br_op1  = ex_fwd1 ? ex_mem_alu_result : rs1_val;
  assign br_op2  = ex_fwd2 ? ex_mem_alu_result : rs2_val;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  logic load_use;
  logic br_haz1;
  logic br_haz2;
  logic branch_haz;
  logic wb_haz;
  logic hazard;
  logic take_branch;

  assign load_use = ID_EX_mem_read && (ID_EX_rd != '0) &&
                    ((ID_EX_rd == rs1) || (uses_rs2 && ID_EX_rd == rs2));

  assign br_haz1 = (rs1 != '0) &&
                   ((ID_EX_reg_write && ID_EX_rd == rs1) ||
                    (ex_mem_mem_read && ex_mem_rd == rs1));
  assign br_haz2 = (rs2 != '0) &&
                   ((ID_EX_reg_write && ID_EX_rd == rs2) ||
                    (ex_mem_mem_read && ex_mem_rd == rs2));
  assign branch_haz = is_beq && (br_haz1 || br_haz2);

`ifdef RF_WRITE_BYPASS_EN
  assign wb_haz = 1'b0;
`else
  // Without the bypass the write lands at the edge; wait one cycle for it.
  assign wb_haz = wb_hit1 || (uses_rs2 && wb_hit2);
`endif

  assign hazard      = load_use || branch_haz || wb_haz;
  assign take_branch = is_beq && br_eq && !hazard;

  // ---------------------------------------------------------------------
  // Fetch-control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    branch      = is_beq;
    br_eq       = (br_op1 == br_op2);
    pc_branch   = IF_ID_pc + imm_b;
    pc_write    = !hazard;
    IF_ID_write = !hazard;
    pc_src      = take_branch;
    IF_flush    = take_branch;
  end

  // ---------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || hazard || take_branch || insn == INS_NONE) begin
      ID_EX_pc         <= '0;
      ID_EX_rs1_data   <= '0;
      ID_EX_rs2_data   <= '0;
      ID_EX_imm        <= '0;
      ID_EX_rs1        <= '0;
      ID_EX_rs2        <= '0;
      ID_EX_rd         <= '0;
      ID_EX_alu_op     <= '0;
      ID_EX_alu_src    <= 1'b0;
      ID_EX_mem_read   <= 1'b0;
      ID_EX_mem_write  <= 1'b0;
      ID_EX_reg_write  <= 1'b0;
      ID_EX_mem_to_reg <= 1'b0;
    end else begin
      ID_EX_pc         <= IF_ID_pc;
      ID_EX_rs1_data   <= rs1_val;
      ID_EX_rs2_data   <= uses_rs2 ? rs2_val : '0;
      ID_EX_imm        <= dec_imm;
      ID_EX_rs1        <= rs1;
      ID_EX_rs2        <= uses_rs2 ? rs2 : '0;
      ID_EX_rd         <= dec_reg_write ? rd : '0;
      ID_EX_alu_op     <= dec_alu_op;
      ID_EX_alu_src    <= dec_alu_src;
      ID_EX_mem_read   <= dec_mem_read;
      ID_EX_mem_write  <= dec_mem_write;
      ID_EX_reg_write  <= dec_reg_write;
      ID_EX_mem_to_reg <= dec_mem_to_reg;
    end
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have reset  in  1  synchronous, active-high; sampled only on rising clk.
REQ-003 SHALL have IF_ID_pc  in  32 and IF_ID_inst  in  32: fetched PC and instruction from the IF/ID register.
REQ-004 SHALL have wb_reg_write  in  1, wb_rd  in  5, wb_data  in  32: register write-back port.
REQ-005 SHALL have ex_mem_reg_write  in  1, ex_mem_mem_read  in  1, ex_mem_rd  in  5, ex_mem_alu_result  in  32: EX/MEM state for forwarding and hazards.
REQ-006 SHALL have pc_write, IF_ID_write, IF_flush, pc_src, branch, br_eq  out  1 each, and pc_branch  out  32: fetch-control outputs, all combinational.
REQ-007 SHALL have ID/EX register outputs: ID_EX_pc  32, ID_EX_rs1_data  32, ID_EX_rs2_data  32, ID_EX_imm  32, ID_EX_rs1/rs2/rd  5 each, ID_EX_alu_op  4, ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write, ID_EX_mem_to_reg  1 each.

Function
REQ-008 SHALL decode add, sub, and, or (0110011), addi (0010011), lw (0000011, funct3 010), sw (0100011, funct3 010), beq (1100011, funct3 000); any other encoding, including 0x00000000, SHALL decode as a bubble with all control bits 0.
REQ-009 SHALL sign-extend immediates to 32 bits per RV32I I/S/B formats; B-immediate bit 0 = 0.
REQ-010 SHALL hold a 32x32 register file, one synchronous write port, two combinational read ports; x0 reads 0 and writes to x0 are discarded.
REQ-011 SHALL flag load-use hazard when ID_EX_mem_read=1, ID_EX_rd!=0, and ID_EX_rd equals a used source (rs1; rs2 only for R-type, sw, beq).
REQ-012 SHALL flag branch hazard for beq when a used source !=0 matches ID_EX_rd with ID_EX_reg_write=1, or matches ex_mem_rd with ex_mem_mem_read=1.
REQ-013 On any hazard: pc_write=0, IF_ID_write=0, pc_src=0, IF_flush=0, and ID/EX loaded with a bubble (all control 0, data 0) on the next edge; otherwise pc_write=IF_ID_write=1.
REQ-014 beq comparison operands SHALL be forwarded, priority: ex_mem_alu_result (ex_mem_reg_write=1, ex_mem_mem_read=0, rd match, rd!=0), then WB bypass (REQ-020), then register file.
REQ-015 branch SHALL equal decoded-beq; br_eq SHALL equal forwarded-rs1 == forwarded-rs2; pc_branch SHALL equal IF_ID_pc + B-immediate, 32-bit wrap-around.
REQ-016 When branch=1, br_eq=1 and no hazard: pc_src=1 and IF_flush=1 in the same cycle; beq SHALL then enter ID/EX as a bubble.
REQ-017 Non-hazard, non-beq instructions SHALL reach ID/EX outputs one cycle after presentation (latency 1); alu_op: add/addi/lw/sw 0000, sub 0001, and 0010, or 0011.

Reset
REQ-018 When reset=1 at a rising edge, all ID/EX outputs and all 32 registers SHALL become 0, overriding stall, flush and write-back in that cycle.
REQ-019 Combinational outputs SHALL be derived only from the reset register state; no extra stall cycles after reset deasserts.

Configuration
REQ-020 RF_WRITE_BYPASS_EN defined: a read of register r in the same cycle as wb_reg_write=1, wb_rd=r!=0 SHALL return wb_data.
REQ-021 RF_WRITE_BYPASS_EN undefined: no bypass; that condition SHALL be an additional hazard handled per REQ-013 for one cycle.

Verification
REQ-022 lw x14,8(x2) then add x5,x19,x14 -> one cycle with pc_write=0, IF_ID_write=0, ID_EX bubble; add issues the next cycle with ID_EX_rs2=14.
REQ-023 After reset, IF_ID_pc=0x1C, IF_ID_inst=beq x1,x10,+24 -> branch=1, br_eq=1, pc_branch=0x34, pc_src=1, IF_flush=1 that cycle.
REQ-024 lw x14 immediately followed by beq x1,x14 -> exactly two stall cycles, then branch resolved with the loaded value forwarded via WB.
REQ-025 wb_reg_write=1, wb_rd=7, wb_data=5 while decoding addi x7,x11 as rs1=x7 -> ID_EX_rs1_data=5 (macro on); 1-cycle stall then 5 (macro off).
REQ-026 reset=1 during a load-use stall -> all ID/EX outputs 0 next edge; write wb_rd=0, wb_data=0xFFFFFFFF -> x0 still reads 0.
